// File: rtl/jtkiwi_pcm_pkg.sv
// Shared state codes and sample constants for the Kageki PCM sequencer.
package jtkiwi_pcm_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LSB  = 2'd1;
  localparam logic [1:0] ST_MSB  = 2'd2;
  localparam logic [1:0] ST_PLAY = 2'd3;

  localparam logic [7:0] PCM_SILENCE = 8'h80;
  localparam logic [7:0] PCM_END     = 8'h00;
endpackage

// File: rtl/jtkiwi_pcm_presc.sv
// Sample-strobe edge detector and modulo-DIV tick generator, shared by PCM channels.
module jtkiwi_pcm_presc #(
  parameter int DIV = 3
)(
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  output logic tick
);
  logic       sample_l;
  logic [2:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_l <= 1'b0;
      cnt      <= 3'd0;
      tick     <= 1'b0;
    end else begin
      sample_l <= sample;
      tick     <= 1'b0;
      if (sample && !sample_l) begin
        if (cnt == 3'(DIV - 1)) begin
          cnt  <= 3'd0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end
endmodule

// File: rtl/jtkiwi_pcm_seq.sv
// Kageki PCM sequencer: pointer lookup, byte prefetch and paced playback.
// Optional JTKIWI_PCM_QUEUE_EN: triggers while busy queue one sel instead of restarting.
module jtkiwi_pcm_seq
  import jtkiwi_pcm_pkg::*;
#(
  parameter logic [15:0] TBL_BASE = 16'h0090,
  parameter int          DIV      = 3
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample,
  input  logic        trig,
  input  logic [5:0]  sel,
  output logic [15:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [7:0]  rom_data,
  output logic [7:0]  pcm,
  output logic        pcm_cen,
  output logic        busy,
  output logic        underrun,
  output logic [1:0]  st
);
  logic       tick, trig_l, cs_l, trig_edge, accept, start;
  logic [5:0] sel_r;
  logic [7:0] lsb, buf_d;
  logic       buf_vld, end_pend;
`ifdef JTKIWI_PCM_QUEUE_EN
  logic       q_vld;
  logic [5:0] q_sel;
`endif

  jtkiwi_pcm_presc #(.DIV(DIV)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (sample),
    .tick   (tick)
  );

  assign trig_edge = trig && !trig_l;
  // cs_l masks an rom_ok left over from the previous request
  assign accept    = rom_cs && rom_ok && cs_l;
  assign busy      = (st != ST_IDLE);
`ifdef JTKIWI_PCM_QUEUE_EN
  assign start = trig_edge && (st == ST_IDLE);
`else
  assign start = trig_edge;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      rom_addr <= 16'd0;
      rom_cs   <= 1'b0;
      cs_l     <= 1'b0;
      trig_l   <= 1'b0;
      pcm      <= PCM_SILENCE;
      pcm_cen  <= 1'b0;
      underrun <= 1'b0;
      sel_r    <= 6'd0;
      lsb      <= 8'd0;
      buf_d    <= 8'd0;
      buf_vld  <= 1'b0;
      end_pend <= 1'b0;
`ifdef JTKIWI_PCM_QUEUE_EN
      q_vld    <= 1'b0;
      q_sel    <= 6'd0;
`endif
    end else begin
      trig_l   <= trig;
      cs_l     <= rom_cs;
      pcm_cen  <= 1'b0;
      underrun <= 1'b0;
      if (start) begin
        st       <= ST_LSB;
        sel_r    <= sel;
        rom_cs   <= 1'b0;
        buf_vld  <= 1'b0;
        end_pend <= 1'b0;
      end else begin
        case (st)
          ST_IDLE: rom_cs <= 1'b0;
          ST_LSB: begin
            // address is loaded while rom_cs is low, then the request is raised
            if (!rom_cs) begin
              rom_addr <= TBL_BASE + {9'd0, sel_r, 1'b0};
              rom_cs   <= 1'b1;
            end else if (accept) begin
              lsb      <= rom_data;
              rom_addr <= rom_addr + 16'd1;
              rom_cs   <= 1'b0;
              st       <= ST_MSB;
            end
          end
          ST_MSB: begin
            if (!rom_cs) rom_cs <= 1'b1;
            else if (accept) begin
              rom_addr <= {rom_data, lsb};
              rom_cs   <= 1'b0;
              buf_vld  <= 1'b0;
              end_pend <= 1'b0;
              st       <= ST_PLAY;
            end
          end
          default: begin
            if (tick && (end_pend || (buf_vld && buf_d == PCM_END))) begin
              pcm      <= PCM_SILENCE;
              rom_cs   <= 1'b0;
              buf_vld  <= 1'b0;
              end_pend <= 1'b0;
`ifdef JTKIWI_PCM_QUEUE_EN
              if (q_vld) begin
                st    <= ST_LSB;
                sel_r <= q_sel;
                q_vld <= 1'b0;
              end else begin
                st <= ST_IDLE;
              end
`else
              st <= ST_IDLE;
`endif
            end else begin
              if (tick) begin
                if (buf_vld) begin
                  pcm     <= buf_d;
                  pcm_cen <= 1'b1;
                  buf_vld <= 1'b0;
                  // last addressable byte: finish on the next tick without wrapping
                  if (rom_addr == 16'hFFFF) end_pend <= 1'b1;
                  else rom_addr <= rom_addr + 16'd1;
                end else begin
                  underrun <= 1'b1;
                end
              end
              if (!buf_vld && !end_pend) begin
                if (!rom_cs) rom_cs <= 1'b1;
                else if (accept) begin
                  buf_d   <= rom_data;
                  buf_vld <= 1'b1;
                  rom_cs  <= 1'b0;
                end
              end
            end
          end
        endcase
      end
`ifdef JTKIWI_PCM_QUEUE_EN
      if (trig_edge && st != ST_IDLE) begin
        q_vld <= 1'b1;
        q_sel <= sel;
      end
`endif
    end
  end
endmodule

// File: tb/tb_jtkiwi_pcm_seq.sv
// Scoreboard bench for jtkiwi_pcm_seq: expected bytes queued at trigger, popped on pcm_cen.
module tb_jtkiwi_pcm_seq;
  logic        clk = 1'b0, rst_n = 1'b0, sample = 1'b0, trig = 1'b0;
  logic [5:0]  sel = 6'd0;
  logic [15:0] rom_addr;
  logic        rom_cs, rom_ok, pcm_cen, busy, underrun;
  logic [7:0]  rom_data, pcm;
  logic [1:0]  st;
  logic        hold = 1'b0;
  logic [2:0]  lat;
  logic [7:0]  mem [0:65535];
  int          n_chk = 0, n_fail = 0, cyc = 0, und_cnt = 0, viol = 0, fall_t = 0;
  logic [7:0]  exp_q [$];
  logic [15:0] flog [$];
  int          cen_t [$];

  jtkiwi_pcm_seq dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .trig(trig), .sel(sel),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
    .pcm(pcm), .pcm_cen(pcm_cen), .busy(busy), .underrun(underrun), .st(st)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // ROM answers a fixed 2 clk after rom_cs rises, unless held off
  always_ff @(posedge clk) begin
    if (!rom_cs) lat <= 3'd0;
    else if (lat != 3'd7) lat <= lat + 3'd1;
  end
  assign rom_ok   = rom_cs && (lat >= 3'd2) && !hold;
  assign rom_data = mem[rom_addr];

  // sample edges every 8 clk -> one tick every 24 clk
  initial forever begin
    repeat (4) @(posedge clk);
    #1 sample = ~sample;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    logic        cs_p, busy_p;
    logic [15:0] a_p;
    cs_p = 1'b0; busy_p = 1'b0; a_p = 16'd0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pcm_cen) begin
          cen_t.push_back(cyc);
          if (exp_q.size() == 0) chk("pcm_unexpected", pcm_cen, 1'b0);
          else chk("pcm", pcm, exp_q.pop_front());
        end
        if (underrun) und_cnt++;
        if (rom_cs && !cs_p) flog.push_back(rom_addr);
        if (rom_cs && cs_p && rom_addr != a_p) viol++;
        if (!busy && busy_p) fall_t = cyc;
      end
      cs_p = rom_cs; busy_p = busy; a_p = rom_addr;
    end
  end

  task automatic pulse_trig(input logic [5:0] s);
    @(negedge clk);
    sel = s; trig = 1'b1;
    repeat (2) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    if (busy) chk(tag, busy, 1'b0);
  endtask

  task automatic wait_cen(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pcm_cen) break;
    end
    if (!pcm_cen) chk(tag, pcm_cen, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h99;
    mem[16'h0090] = 8'h34; mem[16'h0091] = 8'h12;
    mem[16'h0092] = 8'h00; mem[16'h0093] = 8'h30;
    mem[16'h0094] = 8'hFF; mem[16'h0095] = 8'hFF;
    mem[16'h0096] = 8'h00; mem[16'h0097] = 8'h40;
    mem[16'h010E] = 8'h00; mem[16'h010F] = 8'h20;
    mem[16'h1234] = 8'h10; mem[16'h1235] = 8'h20; mem[16'h1236] = 8'h00;
    mem[16'h2000] = 8'h77;
    mem[16'h3000] = 8'h31; mem[16'h3001] = 8'h32; mem[16'h3002] = 8'h33;
    mem[16'h4000] = 8'h41; mem[16'h4001] = 8'h42; mem[16'h4002] = 8'h43; mem[16'h4003] = 8'h44;
    mem[16'hFFFF] = 8'h55;

    repeat (3) @(negedge clk);
    chk("rst_pcm", pcm, 8'h80);
    chk("rst_cs", rom_cs, 1'b0);
    chk("rst_addr", rom_addr, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cen", pcm_cen, 1'b0);
    chk("rst_und", underrun, 1'b0);
    chk("rst_st", st, 2'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // basic sample: 10, 20, terminator
    flog.delete(); cen_t.delete();
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    pulse_trig(6'd0);
    wait_idle("t1_timeout");
    chk("t1_pcm_end", pcm, 8'h80);
    chk("t1_nlog", flog.size(), 5);
    chk("t1_log0", flog[0], 16'h0090);
    chk("t1_log1", flog[1], 16'h0091);
    chk("t1_log2", flog[2], 16'h1234);
    chk("t1_log4", flog[4], 16'h1236);
    chk("t1_gap", cen_t[1] - cen_t[0], 24);
    chk("t1_end_gap", fall_t - cen_t[1], 24);

    // last table entry wraps the pointer offset into 0x010E
    flog.delete();
    exp_q.push_back(8'h77);
    pulse_trig(6'h3F);
    wait_idle("t2_timeout");
    chk("t2_log0", flog[0], 16'h010E);
    chk("t2_log1", flog[1], 16'h010F);
    chk("t2_log2", flog[2], 16'h2000);

    // underrun: rom_ok withheld for 10 ticks
    exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h33);
    pulse_trig(6'd1);
    wait_cen("t3_cen_timeout");
    hold = 1'b1; und_cnt = 0;
    for (int i = 0; i < 1000 && und_cnt < 10; i++) @(negedge clk);
    chk("t3_und", und_cnt, 10);
    chk("t3_pcm_hold", pcm, 8'h31);
    chk("t3_addr_hold", rom_addr, 16'h3001);
    hold = 1'b0;
    wait_idle("t3_timeout");
    chk("t3_und_total", und_cnt, 10);

    // pointer at 0xFFFF: one byte, then end without fetching 0x0000
    flog.delete(); cen_t.delete();
    exp_q.push_back(8'h55);
    pulse_trig(6'd2);
    wait_idle("t4_timeout");
    chk("t4_nlog", flog.size(), 3);
    chk("t4_log2", flog[2], 16'hFFFF);
    chk("t4_pcm", pcm, 8'h80);
    chk("t4_end_gap", fall_t - cen_t[0], 24);

    // retrigger mid-PLAY with sel = 2
    exp_q.push_back(8'h41);
    pulse_trig(6'd3);
    wait_cen("t5_cen_timeout");
    repeat (10) @(negedge clk);
    flog.delete();
`ifdef JTKIWI_PCM_QUEUE_EN
    exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h44);
`endif
    exp_q.push_back(8'h55);
    pulse_trig(6'd2);
    wait_idle("t5_timeout");
`ifdef JTKIWI_PCM_QUEUE_EN
    chk("t5_retrig_addr", flog[3], 16'h0094);
`else
    chk("t5_retrig_addr", flog[0], 16'h0094);
`endif
    chk("t5_pcm", pcm, 8'h80);

    // asynchronous reset during a pending fetch
    exp_q.push_back(8'h41);
    pulse_trig(6'd3);
    wait_cen("t6_cen_timeout");
    hold = 1'b1;
    for (int i = 0; i < 100 && !rom_cs; i++) @(negedge clk);
    chk("t6_pending", rom_cs, 1'b1);
    chk("t6_pcm_before", pcm, 8'h41);
    rst_n = 1'b0;
    #1;
    chk("t6_cs_async", rom_cs, 1'b0);
    chk("t6_pcm_async", pcm, 8'h80);
    @(negedge clk);
    rst_n = 1'b1; hold = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_st", st, 2'd0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_cs", rom_cs, 1'b0);

    chk("exp_drained", exp_q.size(), 0);
    chk("protocol", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jtkiwi_pcm_seq.md
Name: jtkiwi_pcm_seq

Overview:
- Sequencer for Kageki's 8-bit unsigned PCM channel.
- On a trigger edge it does three things in order:
  - looks up the sample's 16-bit start pointer in a ROM table;
  - prefetches sample bytes through a rom_cs/rom_ok handshake;
  - outputs one byte per N rising edges of the YM2203 sample strobe, until it reads a 0x00 terminator.
- Sits between the YM2203 port B outputs and the PCM ROM/SDRAM slot. Its output feeds the DC remover and mixer in the sound subsystem.

Parameters:
- TBL_BASE, 16'h0090, byte address of the pointer table (two bytes per entry, LSB first)
- DIV, 3, rising edges of sample per output byte (legal range 1-7)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- sample  in  1  YM2203 sample strobe, level signal, one clk per edge detect
- trig  in  1  start request; rising edge starts sample sel (port B bit 7)
- sel  in  6  sample index (port B bits 5:0)
- rom_addr  out  16  PCM ROM byte address
- rom_cs  out  1  ROM request
- rom_ok  in  1  rom_data valid for current rom_addr
- rom_data  in  8  ROM byte
- pcm  out  8  unsigned sample, 0x80 = silence
- pcm_cen  out  1  one-clk pulse when pcm updates
- busy  out  1  high in any state except IDLE
- underrun  out  1  one-clk pulse when a tick finds no byte ready
- st  out  2  state code, for debug

Behaviour:
Reset (rst_n low, asynchronous):
- state = IDLE, rom_addr = 0, rom_cs = 0, pcm = 8'h80.
- pcm_cen, busy and underrun = 0.
- Prescaler counter = 0, buffer invalid.

Prescaler:
- Detect the rising edge of sample (register sample_l).
- Each edge increments the counter modulo DIV. On wrap to 0, pulse tick for 1 clk.
- pcm_cen is asserted only on ticks in PLAY. Its 1-clk pulse is registered, in the same cycle pcm updates.
- The prescaler runs in every state and is not reset by triggers.

Handshake:
- rom_addr changes only while rom_cs = 0, or in the cycle a byte is accepted.
- A byte is accepted in a cycle where rom_cs = 1, rom_ok = 1 and rom_cs was already 1 in the previous cycle. This blocks a stale rom_ok.
- rom_cs drops the cycle after acceptance.

States (st codes):
- IDLE (0): rom_cs = 0, pcm = 0x80.
- LSB (1):
  - rom_addr = TBL_BASE + {sel, 1'b0} (16-bit add, wraps).
  - On accept: latch lsb, rom_addr += 1, go to MSB.
- MSB (2): on accept, rom_addr = {rom_data, lsb}, clear buffer, go to PLAY.
- PLAY (3):
  - While the buffer is invalid and no end is pending: rom_cs = 1. On accept, buf = rom_data and buf_vld = 1.
  - On tick with buf_vld:
    - If buf == 0x00, go to IDLE and set pcm = 0x80.
    - Otherwise pcm = buf, pcm_cen = 1, buf_vld = 0.
    - If rom_addr == 16'hFFFF, set end-pending: the next tick goes to IDLE with pcm = 0x80 and no further fetch.
    - Otherwise rom_addr += 1.
  - On tick without buf_vld: underrun = 1, pcm holds, rom_addr holds, fetch continues.

Trigger:
- trig rising edge (registered trig_l) in any state: go to LSB, rom_cs = 0 for at least 1 clk, buf_vld = 0.
- pcm holds its value until a new byte plays or the state returns to IDLE. This overrides a same-cycle accept or tick.
- sel is sampled in the edge cycle.

Reset mid-fetch:
- rom_cs drops asynchronously.
- No handshake state is retained.

Optional Feature:
- JTKIWI_PCM_QUEUE_EN
  - Defined: a trigger edge while busy stores sel in a 1-entry queue; a later edge overwrites the queued sel.
  - Defined: when PLAY ends (terminator or 0xFFFF) with the queue full, go straight to LSB with the queued sel; pcm goes to 0x80 for that transition.
  - Defined: an edge while IDLE starts immediately.
  - Undefined: a trigger always restarts immediately, as in Trigger above; the queue logic is absent.

Decomposition:
- Package jtkiwi_pcm_pkg:
  - state encoding (IDLE = 0, LSB = 1, MSB = 2, PLAY = 3);
  - PCM_SILENCE = 8'h80;
  - PCM_END = 8'h00.
- One natural sub-module: jtkiwi_pcm_presc, the sample edge detector and modulo-DIV tick generator, reusable for other PCM channels.
- The FSM and handshake stay in the top module.

Test Plan:
- Table at 0x0090/0x0091 = 34/12, bytes 0x1234..0x1236 = 10,20,00; trig with sel = 0, rom_ok a fixed 2 clk after rom_cs → pcm = 0x10 then 0x20 on consecutive ticks (every 3rd sample edge), then 0x80 and busy = 0 on the 3rd tick.
- sel = 6'h3F → first table fetch at rom_addr 0x010E, then 0x010F.
- rom_ok held low 10 ticks in PLAY → 10 underrun pulses, pcm stable, rom_addr stable; release → playback resumes with no byte skipped.
- Pointer 0xFFFF with byte 0x55 → pcm = 0x55, next tick pcm = 0x80, IDLE, no fetch at 0x0000.
- Retrigger mid-PLAY with sel = 2 → rom_cs low ≥ 1 clk, next fetch at 0x0094.
  - With JTKIWI_PCM_QUEUE_EN: the current sample finishes first.
- rst_n low during a pending fetch → rom_cs = 0 and pcm = 0x80 in the same cycle (asynchronous), state IDLE after release.
